// File: rtl/data_mem_bridge_if.sv
// SRAM-like data bus between the MEM-stage bridge (master) and the data memory (slave).
// Signal names keep the bridge's port view: _o is driven by the bridge, _i by the memory.
interface data_mem_bridge_if;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o,
    output data_wr_o,
    output data_size_o,
    output data_wstrb_o,
    output data_addr_o,
    output data_wdata_o,
    input  data_addr_ok_i,
    input  data_data_ok_i,
    input  data_rdata_i
  );

  modport slave (
    input  data_req_o,
    input  data_wr_o,
    input  data_size_o,
    input  data_wstrb_o,
    input  data_addr_o,
    input  data_wdata_o,
    output data_addr_ok_i,
    output data_data_ok_i,
    output data_rdata_i
  );
endinterface

// File: rtl/data_mem_bridge.sv
// MEM-stage load/store bridge onto the SRAM-like data bus: one outstanding transaction,
// pipeline stall until completion, and flush-tolerant draining of in-flight accesses.
module data_mem_bridge #(
  parameter bit KSEG_XLATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_en_i,
  input  logic [3:0]                mem_we_i,
  input  logic [1:0]                mem_size_i,
  input  logic [31:0]               mem_addr_i,
  input  logic [31:0]               mem_wdata_i,
  input  logic                      mem_flush_i,
  input  logic                      pipe_stall_i,
  output logic [31:0]               mem_rdata_o,
  output logic                      mem_stall_o,
  data_mem_bridge_if.master         bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  r_state, w_state_d;
  logic        r_cancel, w_cancel_d;
  logic [31:0] r_rdata;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_latch;
  logic        w_wait_ok;
  logic        w_done;
  logic [31:0] w_addr_phys;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) map onto the low 512 MiB.
  always_comb begin
    w_addr_phys = mem_addr_i;
    if (KSEG_XLATE && (mem_addr_i[31:30] == 2'b10)) begin
      w_addr_phys = {3'b000, mem_addr_i[28:0]};
    end
  end

  assign w_wait_ok = (r_state == S_WAIT) && bus.data_data_ok_i;
  assign w_done    = (w_wait_ok && !r_cancel) || (r_state == S_HOLD);

  always_comb begin
    w_state_d  = r_state;
    w_cancel_d = r_cancel;
    w_latch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_en_i && !mem_flush_i) begin
          w_latch   = 1'b1;
          w_state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_flush_i) w_cancel_d = 1'b1;
        if (bus.data_addr_ok_i) w_state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.data_data_ok_i) begin
          w_cancel_d = 1'b0;
          // A flush landing on the data_ok cycle also discards the result.
          if (r_cancel || mem_flush_i) w_state_d = S_IDLE;
          else if (pipe_stall_i)       w_state_d = S_HOLD;
          else                         w_state_d = S_IDLE;
        end else if (mem_flush_i) begin
          w_cancel_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (!pipe_stall_i || mem_flush_i) w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cancel <= 1'b0;
      r_rdata  <= '0;
      r_wr     <= 1'b0;
      r_size   <= '0;
      r_wstrb  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cancel <= w_cancel_d;
      if (w_wait_ok) r_rdata <= bus.data_rdata_i;
      if (w_latch) begin
        r_wr    <= (mem_we_i != 4'b0000);
        r_size  <= mem_size_i;
        r_wstrb <= mem_we_i;
        r_addr  <= w_addr_phys;
        r_wdata <= mem_wdata_i;
      end
    end
  end

  assign bus.data_req_o   = (r_state == S_REQ);
  assign bus.data_wr_o    = r_wr;
  assign bus.data_size_o  = r_size;
  assign bus.data_wstrb_o = r_wstrb;
  assign bus.data_addr_o  = r_addr;
  assign bus.data_wdata_o = r_wdata;

  // Gated by reset so a held mem_en_i cannot stall the pipe while in reset.
  assign mem_stall_o = rst && mem_en_i && !mem_flush_i && !w_done;
  assign mem_rdata_o = w_wait_ok ? bus.data_rdata_i : r_rdata;

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Responder side of the MEM-stage memory-enable request. Takes the pipeline's load/store request (memory enable, byte write mask, address, write data) and runs it as a transaction on the SRAM-like data bus (req/addr_ok/data_ok).
- Returns load data to the MEM stage.
- Raises a stall toward the hazard unit until the access completes.
- Handles exception flushes that arrive mid-transaction.

Parameters:
- KSEG_XLATE, 1, when 1, addresses 0x8000_0000–0xBFFF_FFFF have bits [31:29] cleared on data_addr_o; when 0, addresses pass unchanged.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_en_i  in  1  MEM-stage instruction is a load or store.
- mem_we_i  in  4  byte write enables; 4'b0000 = load.
- mem_size_i  in  2  0 = byte, 1 = half, 2 = word.
- mem_addr_i  in  32  virtual byte address.
- mem_wdata_i  in  32  store data, already lane-aligned.
- mem_flush_i  in  1  MEM stage flushed (exception or eret) this cycle.
- pipe_stall_i  in  1  MEM stage held by another source.
- mem_rdata_o  out  32  load data for the MEM stage.
- mem_stall_o  out  1  request the pipeline to hold the MEM stage.
- data_req_o  out  1  bus request valid.
- data_wr_o  out  1  1 = write.
- data_size_o  out  2  copy of mem_size_i.
- data_wstrb_o  out  4  copy of mem_we_i.
- data_addr_o  out  32  physical address.
- data_wdata_o  out  32  write data.
- data_addr_ok_i  in  1  bus accepted the request this cycle.
- data_data_ok_i  in  1  bus completed the transaction this cycle.
- data_rdata_i  in  32  read data, valid with data_data_ok_i.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cancel_q=0, rdata_q=0.
  - All bus outputs 0; mem_stall_o=0; mem_rdata_o=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - On mem_en_i & ~mem_flush_i: latch wr, size, wstrb, translated address and wdata into request registers, then go to REQ.
- REQ:
  - data_req_o=1; all bus fields driven from the request registers, stable until data_addr_ok_i.
  - On data_addr_ok_i, go to WAIT.
- WAIT:
  - data_req_o=0.
  - On data_data_ok_i: rdata_q<=data_rdata_i (loads and stores alike).
    - If cancel_q, clear cancel_q and go to IDLE.
    - Else if pipe_stall_i, go to HOLD.
    - Else go to IDLE.
- Same-cycle addr_ok and data_ok:
  - Both asserted in REQ is illegal on this bus.
  - data_data_ok_i is ignored in every state except WAIT.
- HOLD (completed, MEM stage still frozen):
  - Go to IDLE when pipe_stall_i=0 or mem_flush_i=1.
- Completion:
  - done = (WAIT & data_data_ok_i & ~cancel_q) | HOLD.
  - mem_stall_o = mem_en_i & ~mem_flush_i & ~done.
  - Minimum load/store latency, no bus wait states: request seen in cycle 0, req in cycle 1 with addr_ok, data_ok in cycle 2. mem_stall_o is high in cycles 0–1 and low in cycle 2.
- Read data:
  - mem_rdata_o = data_rdata_i when (WAIT & data_data_ok_i), else rdata_q.
- Flush:
  - mem_flush_i in REQ or WAIT sets cancel_q. The bus transaction is not aborted; req stays held until addr_ok, and the response is still consumed.
  - The result is discarded: no HOLD; rdata_q still updates, but the pipeline ignores it because no instruction completes.
  - mem_flush_i in HOLD discards the held result.
- Back-to-back access after a flush:
  - A new mem_en_i arriving while a cancelled transaction drains keeps mem_stall_o=1.
  - The new request starts only from IDLE.
- Outstanding limit:
  - No new transaction is issued until the previous data_ok; at most one transaction is outstanding.
- Address translation:
  - With KSEG_XLATE=1, 0x9FC0_0010 maps to 0x1FC0_0010 and 0xA000_0004 maps to 0x0000_0004.
  - 0x0040_0000 and 0xC000_0000 pass unchanged.
- Mid-transaction reset: returns immediately to reset values; any bus response already in flight is ignored.

Test Plan:
- Load, zero-wait bus: en=1, we=0, addr=0xBFC0_0100; addr_ok in cycle 1, data_ok in cycle 2 with rdata=0x1234_5678. Required: data_addr_o=0x1FC0_0100, data_wr_o=0, stall high in cycles 0–1, low in cycle 2, mem_rdata_o=0x1234_5678 in cycle 2.
- Store with bus wait states: we=4'b0011, size=1, wdata=0x0000_BEEF; addr_ok delayed 3 cycles. Required: req, wstrb, addr and wdata held stable across all 3 cycles; data_ok 2 cycles later; stall drops in the data_ok cycle.
- Completion under external stall: pipe_stall_i=1 when data_ok arrives with rdata=0xCAFE_F00D. Required: HOLD entered, stall=0, mem_rdata_o holds 0xCAFE_F00D for 4 cycles, IDLE when pipe_stall_i falls.
- Flush in WAIT, then new load: flush pulses in WAIT; next load asserts en in the following cycle. Required: stall stays 1 until the old data_ok; the old data is not delivered as done; the new req is issued the cycle after the drain.
- Reset mid-REQ: rst low while data_req_o=1. Required: data_req_o=0 and mem_stall_o=0 asynchronously, state IDLE, mem_rdata_o=0.
- KSEG_XLATE=0 build: addr=0x8000_0040 appears unchanged on data_addr_o.
